port_sample_fifo: RTL and testbench

PORT_SAMPLE_FIFO -- requirements
Module: port_sample_fifo

---
 rtl/port_sample_fifo.sv | 151 +++++++++++++++
 tb/tb_port_sample_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/port_sample_fifo.sv
// Sample FIFO behind a four-address processor port block: data/pop, status, count, control.
// Define PORT_SAMPLE_FIFO_IRQ_EN to build the fill-level interrupt state machine.
module port_sample_fifo #(
    parameter int         DEPTH         = 16,
    parameter logic [7:0] BASE_PORT     = 8'h00,
    parameter int         IRQ_THRESHOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    input  logic [7:0] sample_data,
    input  logic       sample_valid,
    output logic       sample_ready
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [7:0] DATA_PORT   = BASE_PORT;
    localparam logic [7:0] STATUS_PORT = BASE_PORT + 8'd1;
    localparam logic [7:0] COUNT_PORT  = BASE_PORT + 8'd2;
    localparam logic [7:0] CTRL_PORT   = BASE_PORT + 8'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          overflow;
    logic          full;
    logic          empty;
    logic          ctrl_wr;
    logic          flush;
    logic          pop;
    logic          push;
    logic          irq_status;
    logic          irq_en_status;
    logic [7:0]    read_mux;

    assign full         = (count == (AW+1)'(DEPTH));
    assign empty        = (count == '0);
    assign sample_ready = !full;

    assign ctrl_wr = write_strobe && (port_id == CTRL_PORT);
    assign flush   = ctrl_wr && out_port[0];
    assign pop     = read_strobe && (port_id == DATA_PORT) && !empty && !flush;
    // A full FIFO drops the sample even when a pop frees a slot this same cycle.
    assign push    = sample_valid && !full && !flush;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            if (ctrl_wr && out_port[1])
                overflow <= 1'b0;
            else if (sample_valid && full && !flush)
                overflow <= 1'b1;
        end
    end

    // NOTE: storage has no reset; the empty check keeps stale contents from reaching in_port.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_data;
    end

`ifdef PORT_SAMPLE_FIFO_IRQ_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       irq_en;
    logic       at_level;

    assign at_level = (count >= (AW+1)'(IRQ_THRESHOLD));

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (irq_en && at_level) state_next = ST_REQ;
            ST_REQ: begin
                if (!irq_en)           state_next = ST_IDLE;
                else if (interrupt_ack) state_next = ST_LOCK;
            end
            ST_LOCK: if (!at_level || !irq_en) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            irq_en    <= 1'b0;
            interrupt <= 1'b0;
        end else begin
            state     <= state_next;
            interrupt <= (state_next == ST_REQ);
            if (ctrl_wr) irq_en <= out_port[2];
        end
    end

    assign irq_status    = interrupt;
    assign irq_en_status = irq_en;

    logic unused_bits;
    assign unused_bits = &{1'b0, out_port[7:3]};
`else
    assign interrupt     = 1'b0;
    assign irq_status    = 1'b0;
    assign irq_en_status = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, out_port[7:2], interrupt_ack};
`endif

    // NOTE: defaulting read_mux first keeps this block free of inferred latches.
    always_comb begin
        read_mux = 8'h00;
        case (port_id)
            DATA_PORT:   read_mux = empty ? 8'h00 : mem[rd_ptr];
            STATUS_PORT: read_mux = {full, empty, overflow, irq_status, irq_en_status, 3'b000};
            COUNT_PORT:  read_mux = 8'(count);
            default:     read_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) in_port <= 8'h00;
        else       in_port <= read_mux;
    end

endmodule

// File: tb/tb_port_sample_fifo.sv
// Randomised and directed bench for port_sample_fifo against a queue-based reference model.
// Honours PORT_SAMPLE_FIFO_IRQ_EN the same way the design does.
module tb_port_sample_fifo;

    localparam int         DEPTH = 16;
    localparam logic [7:0] B     = 8'h20;
    localparam int         THR   = 8;

    logic       clk;
    logic       reset;
    logic [7:0] port_id;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;

    port_sample_fifo #(.DEPTH(DEPTH), .BASE_PORT(B), .IRQ_THRESHOLD(THR)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
        .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
        .interrupt(interrupt), .interrupt_ack(interrupt_ack), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: contents as a queue, plus the flag bits and interrupt phase.
    logic [7:0] q[$];
    bit m_ovf, m_irq_en, m_req, m_locked;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] p);
        bit irq_built;
`ifdef PORT_SAMPLE_FIFO_IRQ_EN
        irq_built = 1'b1;
`else
        irq_built = 1'b0;
`endif
        if (p == B)        return (q.size() > 0) ? q[0] : 8'h00;
        if (p == B + 8'd1) return {q.size() == DEPTH, q.size() == 0, m_ovf,
                                   irq_built & m_req, irq_built & m_irq_en, 3'b000};
        if (p == B + 8'd2) return 8'(q.size());
        return 8'h00;
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf = 0; m_irq_en = 0; m_req = 0; m_locked = 0;
    endtask

    task automatic idle();
        port_id = 8'h00; read_strobe = 0; write_strobe = 0; out_port = 8'h00;
        interrupt_ack = 0; sample_data = 8'h00; sample_valid = 0;
    endtask

    // One clock: check pre-edge outputs, advance the model, check post-edge outputs.
    task automatic tick();
        logic [7:0] exp_in;
        int  pre;
        bit  ctrl, flush, pop, push;
        pre = q.size();
        check("sample_ready", {7'd0, sample_ready}, {7'd0, pre < DEPTH});
        exp_in = model_read(port_id);
        ctrl  = write_strobe && (port_id == B + 8'd3);
        flush = ctrl && out_port[0];
        pop   = read_strobe && (port_id == B) && (pre > 0);
        push  = sample_valid && (pre < DEPTH);
`ifdef PORT_SAMPLE_FIFO_IRQ_EN
        if (m_req) begin
            if (!m_irq_en) m_req = 0;
            else if (interrupt_ack) begin m_req = 0; m_locked = 1; end
        end else if (m_locked) begin
            if (pre < THR || !m_irq_en) m_locked = 0;
        end else if (m_irq_en && pre >= THR) begin
            m_req = 1;
        end
`endif
        if (ctrl && out_port[1]) m_ovf = 0;
        else if (sample_valid && pre == DEPTH && !flush) m_ovf = 1;
        if (ctrl) m_irq_en = out_port[2];
        if (flush) q.delete();
        else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(sample_data);
        end
        @(posedge clk);
        #1;
        check("in_port", in_port, exp_in);
        check("interrupt", {7'd0, interrupt}, {7'd0, m_req});
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        sample_valid = 1; sample_data = d; tick(); idle();
    endtask

    task automatic rd(input logic [7:0] p, output logic [7:0] v);
        port_id = p; read_strobe = 1; tick(); v = in_port; idle();
    endtask

    task automatic wr(input logic [7:0] d);
        port_id = B + 8'd3; write_strobe = 1; out_port = d; tick(); idle();
    endtask

    logic [7:0] v;

    initial begin
        idle();
        reset = 1;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset in_port", in_port, 8'h00);
        check("reset interrupt", {7'd0, interrupt}, 8'h00);
        reset = 0;
        #1;
        check("ready after reset", {7'd0, sample_ready}, 8'h01);

        // Three samples in, count, drain in order, then empty status.
        push(8'h11); push(8'h22); push(8'h33);
        rd(B + 8'd2, v); check("count 3", v, 8'h03);
        rd(B, v); check("pop 1", v, 8'h11);
        rd(B, v); check("pop 2", v, 8'h22);
        rd(B, v); check("pop 3", v, 8'h33);
        rd(B + 8'd1, v); check("status empty", v, 8'h40);
        rd(B, v); check("pop empty", v, 8'h00);
        rd(B + 8'd3, v); check("ctrl reads zero", v, 8'h00);

        // Overfill by one, then clear overflow.
        for (int i = 1; i <= 17; i++) push(8'(i));
        rd(B + 8'd2, v); check("count full", v, 8'h10);
        rd(B + 8'd1, v); check("status full+ovf", v, 8'hA0);
        wr(8'h02);
        rd(B + 8'd1, v); check("status ovf cleared", v, 8'h80);

        // Full with push+pop: the push is a drop, the pop still happens.
        sample_valid = 1; sample_data = 8'hEE; port_id = B; read_strobe = 1;
        tick(); idle();
        check("full push+pop head", in_port, 8'h01);
        rd(B + 8'd2, v); check("count after full push+pop", v, 8'h0F);
        rd(B + 8'd1, v); check("ovf after full push+pop", v, 8'h20);

        // Half-full push+pop across the pointer wrap.
        wr(8'h03);
        for (int i = 0; i < 12; i++) push(8'h80 + 8'(i));
        for (int i = 0; i < 8; i++) rd(B, v);
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1; sample_data = 8'hC0 + 8'(i); port_id = B; read_strobe = 1;
            tick(); idle();
        end
        rd(B + 8'd2, v); check("count steady over wrap", v, 8'h04);
        rd(B, v); check("order after wrap", v, 8'hC6);

`ifdef PORT_SAMPLE_FIFO_IRQ_EN
        wr(8'h07);
        for (int i = 0; i < 8; i++) push(8'(i));
        check("irq not yet", {7'd0, interrupt}, 8'h00);
        tick();
        check("irq raised", {7'd0, interrupt}, 8'h01);
        interrupt_ack = 1; tick(); idle();
        check("irq acked", {7'd0, interrupt}, 8'h00);
        push(8'h55); tick();
        check("irq locked at 9", {7'd0, interrupt}, 8'h00);
        rd(B, v); rd(B, v); push(8'h66); tick();
        check("irq reasserts", {7'd0, interrupt}, 8'h01);
        wr(8'h00);
        check("irq held during disable", {7'd0, interrupt}, 8'h01);
        tick();
        check("irq dropped by disable", {7'd0, interrupt}, 8'h00);
`endif

        // Flush wins over a simultaneous push.
        wr(8'h03);
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        port_id = B + 8'd3; write_strobe = 1; out_port = 8'h01;
        sample_valid = 1; sample_data = 8'hFF;
        tick(); idle();
        rd(B + 8'd2, v); check("flush count", v, 8'h00);
        rd(B + 8'd1, v); check("flush status", v, 8'h40);
        rd(B, v); check("flush data", v, 8'h00);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [7:0] w;
            r = $urandom_range(0, 4);
            port_id = (r == 4) ? 8'($urandom) : B + 8'(r);
            read_strobe   = ($urandom_range(0, 9) < 4);
            write_strobe  = ($urandom_range(0, 99) < 8);
            w = 8'($urandom);
            w[0] = ($urandom_range(0, 9) == 0);
            w[2] = ($urandom_range(0, 3) != 0);
            out_port      = w;
            interrupt_ack = ($urandom_range(0, 4) == 0);
            sample_valid  = ($urandom_range(0, 9) < 6);
            sample_data   = 8'($urandom);
            tick();
        end
        idle();

        // Reset in the middle of a push and pop abandons both.
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        sample_valid = 1; sample_data = 8'h99; port_id = B; read_strobe = 1; interrupt_ack = 1;
        #1 reset = 1;
        @(posedge clk);
        #1;
        model_clear();
        check("mid reset in_port", in_port, 8'h00);
        check("mid reset interrupt", {7'd0, interrupt}, 8'h00);
        @(negedge clk);
        reset = 0;
        idle();
        rd(B + 8'd2, v); check("count after mid reset", v, 8'h00);
        rd(B + 8'd1, v); check("status after mid reset", v, 8'h40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
